// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and jump constants for the ALU sequencer.
package alu_pkg;

    localparam logic [3:0] OP_MOVE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_LI   = 4'hF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    localparam logic [7:0] JUMP_TAKEN = 8'hFF;

    // Opcodes whose ALU result is written back to R[d].
    function automatic logic writes_alu(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == OP_ADDI) || (op == OP_LI);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Memory and ALU bus of the sequencer; master = sequencer, slave = memories/ALU.
// Handshake: a transfer completes at the rising edge where valid is high while req is high;
// req and its address/data stay constant until then, and valid without req is ignored.
interface alu_sequencer_if #(parameter int WIDTH = 8);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_valid;
    logic [WIDTH-1:0] imem_data;
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_valid;
    logic [WIDTH-1:0] alu_instr;
    logic [WIDTH-1:0] alu_in0;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_jump;
    logic             alu_overflow;

    modport master (
        output imem_req, imem_addr, input imem_valid, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_valid,
        output alu_instr, alu_in0, alu_in1, input alu_out, alu_jump, alu_overflow
    );

    modport slave (
        input imem_req, imem_addr, output imem_valid, imem_data,
        input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_valid,
        input alu_instr, alu_in0, alu_in1, output alu_out, alu_jump, alu_overflow
    );
endinterface

// File: rtl/seq_regfile.sv
// 4-entry register file: two asynchronous read ports, one synchronous write port.
module seq_regfile #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [1:0]       rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             we,
    input  logic [1:0]       wa,
    input  logic [WIDTH-1:0] wd
);
    logic [WIDTH-1:0] regs [4];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving an external 8-bit ALU.
// `ALU_SEQ_OVERFLOW_TRAP_EN: signed ADD overflow halts with trap instead of committing.
import alu_pkg::*;

module alu_sequencer #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           ovf_flag,
    output logic           trap,
    output logic [2:0]     dbg_state,
    alu_sequencer_if.master bus
);
    logic [2:0]       state;
    logic [WIDTH-1:0] pc, ir, res_q, jump_q, mem_q;
    logic [WIDTH-1:0] rd_val, rt_val, wdata, next_pc;
    logic             ovf_q, taken, trap_hit, reg_we;
    logic [3:0]       op;
    logic [1:0]       d, t, waddr;

    assign op = ir[7:4];
    assign d  = ir[3:2];
    assign t  = ir[1:0];

    seq_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk(clk), .rst(rst),
        .ra_addr(d), .ra_data(rd_val),
        .rb_addr(t), .rb_data(rt_val),
        .we(reg_we), .wa(waddr), .wd(wdata)
    );

    assign bus.imem_req   = (state == ST_FETCH);
    assign bus.imem_addr  = (state == ST_FETCH) ? pc : '0;
    assign bus.dmem_req   = (state == ST_MEM);
    assign bus.dmem_we    = (state == ST_MEM) && (op == OP_SW);
    assign bus.dmem_addr  = (state == ST_MEM) ? rt_val : '0;
    assign bus.dmem_wdata = ((state == ST_MEM) && (op == OP_SW)) ? rd_val : '0;
    assign bus.alu_instr  = ir;
    assign bus.alu_in1    = rt_val;

    always_comb begin
        bus.alu_in0 = rd_val;
        if (op == OP_MOVE || op == OP_NOT)      bus.alu_in0 = rt_val;
        else if (op == OP_ADDI || op == OP_LI)  bus.alu_in0 = {{(WIDTH-2){1'b0}}, t};
    end

    assign busy      = (state == ST_FETCH) || (state == ST_EXEC) ||
                       (state == ST_MEM)   || (state == ST_WB);
    assign dbg_state = state;
    assign taken     = (jump_q == JUMP_TAKEN);

`ifdef ALU_SEQ_OVERFLOW_TRAP_EN
    assign trap_hit = (op == OP_ADD) && ovf_q;
    assign trap     = (state == ST_HALT);
`else
    assign trap_hit = 1'b0;
    assign trap     = 1'b0;
`endif

    // Branch/jump targets read R[t] in WB, before any same-edge register write lands.
    always_comb begin
        next_pc = pc + WIDTH'(1);
        case (op)
            OP_J, OP_JAL:   if (taken) next_pc = rt_val;
            OP_BEQ, OP_BNE: if (taken) next_pc = pc + WIDTH'(2);
            default: ;
        endcase
    end

    assign reg_we = (state == ST_WB) && !trap_hit &&
                    (writes_alu(op) || op == OP_LW || (op == OP_JAL && taken));
    assign waddr  = (op == OP_JAL) ? 2'd3 : d;
    assign wdata  = (op == OP_LW) ? mem_q : (op == OP_JAL) ? pc + WIDTH'(1) : res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            res_q    <= '0;
            jump_q   <= '0;
            mem_q    <= '0;
            ovf_q    <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:  if (start) state <= ST_FETCH;
                ST_FETCH: if (bus.imem_valid) begin
                    ir    <= bus.imem_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q  <= bus.alu_out;
                    jump_q <= bus.alu_jump;
                    ovf_q  <= bus.alu_overflow;
                    state  <= (op == OP_LW || op == OP_SW) ? ST_MEM : ST_WB;
                end
                ST_MEM:   if (bus.dmem_valid) begin
                    mem_q <= bus.dmem_rdata;
                    state <= ST_WB;
                end
                ST_WB: begin
                    if (op == OP_ADD && ovf_q) ovf_flag <= 1'b1;
                    if (trap_hit) begin
                        state <= ST_HALT;
                    end else begin
                        pc    <= next_pc;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule
